arm_flag_commit: RTL

Execute-stage commit unit sitting directly downstream of the ARM ALU. Each cycle it takes the ALU result and raw flags for one instruction, evaluates the instruction's condition field against the architectural NZCV register, and conditionally updates NZCV. It registers the result with a write-enable toward the register-file writeback stage, using a valid/ready handshake so writeback can stall execute.

---
 rtl/arm_pkg.sv | 51 +++++
 rtl/arm_cond_check.sv | 42 ++++
 rtl/arm_flag_commit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: constants and helpers shared by the execute-stage commit unit.
//   - ALU opcode encodings (AND 0000 ... MVN 1111)
//   - ARM condition-field encodings (EQ 0000 ... NV 1111)
//   - is_compare(op): TST/TEQ/CMP/CMN, which set flags but never write back
//   - is_arith(op):   opcodes whose C and V come from the adder
package arm_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  function automatic logic is_compare(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) || (op == OP_ADC) ||
           (op == OP_SBC) || (op == OP_RSC) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check: evaluates an ARM condition field against NZCV.
// Purely combinational.
//   cond [3:0] in  condition field
//   nzcv [3:0] in  flags {N,Z,C,V}
//   pass       out condition satisfied
module arm_cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0; // NV: never
    endcase
  end

endmodule

// File: rtl/arm_flag_commit.sv
// arm_flag_commit: execute-stage commit unit downstream of the ALU.
// Evaluates the condition field against the architectural NZCV, updates
// NZCV conditionally, and registers result/rd/write-enable toward writeback.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready, so the single output register can be
// refilled in the same cycle it drains (one instruction per cycle). While
// out_valid && !out_ready the output, flags and counters hold.
//
// Optional build macro ARM_MSR_PORT_EN adds msr_we/msr_nzcv, a direct NZCV
// write that takes priority over any instruction flag update that cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     ALU-side handshake
//   in_op, in_cond, in_s  opcode, condition field, set-flags bit
//   in_rd, in_result      destination and ALU result
//   in_nf/zf/cf/vf, in_shc ALU flags and shifter carry-out
//   out_valid/out_ready   writeback-side handshake
//   out_rd, out_result, out_we  registered writeback payload
//   nzcv                  architectural flags {N,Z,C,V}
//   cond_pass             condition result for the current input
//   retire_cnt, skip_cnt  saturating accept / condition-failed counters
module arm_flag_commit
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_cond,
  input  logic        in_s,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_nf,
  input  logic        in_zf,
  input  logic        in_cf,
  input  logic        in_vf,
  input  logic        in_shc,
`ifdef ARM_MSR_PORT_EN
  input  logic        msr_we,
  input  logic [3:0]  msr_nzcv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_rd,
  output logic [31:0] out_result,
  output logic        out_we,
  output logic [3:0]  nzcv,
  output logic        cond_pass,
  output logic [15:0] retire_cnt,
  output logic [15:0] skip_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_rd_q, out_rd_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_we_q, out_we_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic        accept;

  arm_cond_check u_cond_check (
    .cond (in_cond),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_rd_d     = out_rd_q;
    out_result_d = out_result_q;
    out_we_d     = out_we_q;
    nzcv_d       = nzcv_q;
    retire_cnt_d = retire_cnt_q;
    skip_cnt_d   = skip_cnt_q;

    if (accept) begin
      // Condition-failed instructions still retire, just without a write.
      out_valid_d  = 1'b1;
      out_rd_d     = in_rd;
      out_result_d = in_result;
      out_we_d     = cond_pass && !is_compare(in_op);

      if (cond_pass && (in_s || is_compare(in_op))) begin
        if (is_arith(in_op)) begin
          nzcv_d = {in_nf, in_zf, in_cf, in_vf};
        end else begin
          // Logical ops take C from the shifter and leave V alone.
          nzcv_d = {in_nf, in_zf, in_shc, nzcv_q[0]};
        end
      end

      if (retire_cnt_q != 16'hFFFF) retire_cnt_d = retire_cnt_q + 16'd1;
      if (!cond_pass && (skip_cnt_q != 16'hFFFF)) skip_cnt_d = skip_cnt_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_we_d    = 1'b0;
    end

`ifdef ARM_MSR_PORT_EN
    if (msr_we) nzcv_d = msr_nzcv;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_rd_q     <= 4'd0;
      out_result_q <= 32'd0;
      out_we_q     <= 1'b0;
      nzcv_q       <= 4'd0;
      retire_cnt_q <= 16'd0;
      skip_cnt_q   <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_result_q <= out_result_d;
      out_we_q     <= out_we_d;
      nzcv_q       <= nzcv_d;
      retire_cnt_q <= retire_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign out_we     = out_we_q;
  assign nzcv       = nzcv_q;
  assign retire_cnt = retire_cnt_q;
  assign skip_cnt   = skip_cnt_q;

endmodule
